// File: rtl/iterative_divider.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU; WIDTH+3 cycles start-to-valid, 3 for special-case bypass.
// No backpressure: start_i is taken only when idle, valid_o is a one-cycle pulse, kill_i aborts without a result.
package iterative_divider_pkg;
  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_INIT = 2'd1,
    D_CALC = 2'd2,
    D_SIGN = 2'd3
  } div_states_e;
endpackage

module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int               CW      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_states_e      state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d, dsr_q, dsr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qsign_q, qsign_d, rsign_q, rsign_d;
  logic             valid_q, valid_d;

  logic             is_signed, a_neg, b_neg, div_zero, sgn_ovf, special;
  logic [WIDTH+1:0] cand;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] quo_fin, rem_fin;

  // a_q/b_q keep the raw operands for the whole operation so special cases can be recognised at the end.
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[WIDTH-1];
  assign b_neg     = is_signed & b_q[WIDTH-1];
  assign div_zero  = (b_q == '0);
  assign sgn_ovf   = is_signed && (a_q == MIN_NEG) && (b_q == '1);
  assign special   = div_zero | sgn_ovf;

  assign cand = {rem_q, quo_q[WIDTH-1]};
  assign ge   = (cand >= {2'b00, dsr_q});
  assign sub  = cand[WIDTH:0] - {1'b0, dsr_q};

  always_comb begin
    quo_fin = qsign_q ? -quo_q : quo_q;
    rem_fin = rsign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    if (div_zero) begin
      quo_fin = '1;
      rem_fin = a_q;
    end else if (sgn_ovf) begin
      quo_fin = MIN_NEG;
      rem_fin = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    valid_d  = 1'b0;
    if (kill_i) begin
      state_d = D_IDLE;
    end else begin
      unique case (state_q)
        D_IDLE: begin
          if (start_i) begin
            op_d    = op_i;
            a_d     = dividend_i;
            b_d     = divisor_i;
            state_d = D_INIT;
          end
        end
        D_INIT: begin
          quo_d   = a_neg ? -a_q : a_q;
          dsr_d   = b_neg ? -b_q : b_q;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          cnt_d   = CW'(WIDTH - 1);
          rem_d   = '0;
          state_d = (FAST_SPECIAL && special) ? D_SIGN : D_CALC;
        end
        D_CALC: begin
          rem_d = ge ? sub : cand[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = D_SIGN;
          end
        end
        D_SIGN: begin
          result_d = op_q[1] ? rem_fin : quo_fin;
          valid_d  = 1'b1;
          state_d  = D_IDLE;
        end
        default: state_d = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= D_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o   = (state_q != D_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule
